multi_queue_fifo_service: RTL and testbench
===========================================

// Module: multi_queue_fifo_service
// PURPOSE
//  Single-clock N-queue FIFO. One ingress stream carries a channel id and is steered into per-channel queues.
//  Egress arbitrates round-robin across non-empty queues onto one stream.
//  Successor to the single-queue FIFO service: per-queue fill/almost-full, optional drop-on-full mode, per-queue
//  overflow counters, in/out beat statistics. Sits between the packet parser and per-flow consumers.
// PARAMETERS
//  NUM_QUEUES        4     number of logical queues, >=2, power of two
//  SYMBOLS_PER_BEAT  64    symbols per data beat
//  BITS_PER_SYMBOL   8     bits per symbol; DW = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL
//  FIFO_DEPTH        512   entries per queue, power of two
//  FULL_LEVEL        450   almost_full threshold per queue, < FIFO_DEPTH
//  DROP_ON_FULL      0     0: backpressure on full; 1: in_ready tied 1, writes to a full queue are dropped
// PORTS
//  Clk          in   1              clock, all logic on rising edge
//  Rst          in   1              asynchronous reset, active high
//  in_data      in   DW             ingress beat
//  in_chan      in   CW             target queue, CW=$clog2(NUM_QUEUES)
//  in_valid     in   1              ingress beat valid
//  in_ready     out  1              ingress accept
//  out_data     out  DW             egress beat
//  out_chan     out  CW             queue the egress beat came from
//  out_valid    out  1              egress valid
//  out_ready    in   1              egress accept
//  fill_level   out  NUM_QUEUES*FW  per-queue occupancy, FW=$clog2(FIFO_DEPTH)+1, queue q at [q*FW+:FW]
//  almost_full  out  NUM_QUEUES     per-queue fill_level >= FULL_LEVEL
//  overflow     out  NUM_QUEUES*32  per-queue dropped-beat count (DROP_ON_FULL=1 only, else 0)
//  stats_in     out  32             accepted ingress beats
//  stats_out    out  32             accepted egress beats
// BEHAVIOUR
//  Reset: all queues empty, out_valid=0, out_data/out_chan=0, fill_level=0, almost_full=0, overflow=0,
//   stats_in=stats_out=0, RR pointer=0. in_ready=0 while Rst high; afterwards per the rules below.
//  Ingress: beat accepted when in_valid&&in_ready. DROP_ON_FULL=0: in_ready = (fill_level[in_chan]!=FIFO_DEPTH),
//   combinational on in_chan; a pop from a full queue in the same cycle does not free space that cycle.
//   DROP_ON_FULL=1: in_ready=1; a beat to a full queue is discarded and overflow[in_chan] increments.
//  stats_in counts accepted beats only, dropped beats included. All counters are 32-bit and wrap.
//  Egress: one output register stage. It loads when empty or when out_valid&&out_ready.
//   Load source: the first non-empty queue at or after the RR pointer. Pointer then moves to granted+1 mod NUM_QUEUES.
//   out_data/out_chan hold stable while out_valid&&!out_ready. Never hold out_valid=1 without data.
//  Latency: beat accepted in cycle t into an empty idle system -> out_valid=1 in cycle t+2.
//   Throughput is 1 beat/cycle with out_ready held high.
//  fill_level[q] counts beats stored in queue q, excluding the beat in the output register.
//   It updates the cycle after a push or pop. Simultaneous push and pop of the same queue leaves it unchanged.
//  Ordering is FIFO within each queue. There is no ordering guarantee across queues.
//  Pointer wrap is modulo FIFO_DEPTH, with a separate full/empty bit in FW.
//  Reset mid-operation discards all stored beats and the output register immediately.
// STRUCTURE
//  Package mq_fifo_pkg: localparams CW, FW, DW functions; typedef chan_t, fill_t; typedef struct {data,chan} beat_t.
//  Sub-module mq_queue: one single-clock show-ahead FIFO (M20K-inferable RAM, wr/rd ptrs, fill count).
//   Instantiated NUM_QUEUES times via generate.
//  Top holds steering decode, RR arbiter, output register, and counters.
// TESTING
//  1 Reset, push 3 beats to q2 (0xA1,0xA2,0xA3), out_ready=1 -> outputs 0xA1..0xA3 chan=2 from cycle t+2,
//    stats_in=stats_out=3.
//  2 One beat each in q0..q3, out_ready=1 -> out_chan order 0,1,2,3; refill q3,q0 -> order continues 0,3.
//  3 DROP_ON_FULL=0, out_ready=0, push FIFO_DEPTH+1 beats to q1 -> almost_full[1] at FULL_LEVEL.
//    in_ready=0 at 512 stored+1 in register; fill_level[1]=512.
//  4 DROP_ON_FULL=1, same stimulus +5 extra -> overflow[1]=5, other queues' overflow=0, no data corruption.
//  5 out_ready toggled randomly 50% on 2000 random-chan beats -> per-queue order preserved.
//    out_data stable while stalled; stats_in=stats_out when drained.
//  6 Assert Rst mid-burst with 10 beats stored -> next cycle out_valid=0, all fill_level=0.
//    New beat after release appears at t+2.

Source files
------------

// File: rtl/mq_fifo_pkg.sv
// Shared width helpers and default-configuration types for the multi-queue FIFO service.
package mq_fifo_pkg;

    function automatic int unsigned calc_cw(input int unsigned num_queues);
        return $clog2(num_queues);
    endfunction

    function automatic int unsigned calc_fw(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned calc_dw(input int unsigned symbols, input int unsigned bits);
        return symbols * bits;
    endfunction

    localparam int unsigned DefNumQueues = 4;
    localparam int unsigned DefDepth     = 512;
    localparam int unsigned DefCw        = calc_cw(DefNumQueues);
    localparam int unsigned DefFw        = calc_fw(DefDepth);
    localparam int unsigned DefDw        = calc_dw(64, 8);

    typedef logic [DefCw-1:0] chan_t;
    typedef logic [DefFw-1:0] fill_t;

    typedef struct packed {
        logic [DefDw-1:0] data;
        chan_t            chan;
    } beat_t;

endpackage

// File: rtl/mq_queue.sv
// Single-clock show-ahead FIFO: the head entry is on rd_data_o whenever the queue is non-empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mq_queue
    import mq_fifo_pkg::*;
#(
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned FW   = calc_fw(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [FW-1:0] fill_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [FW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (wr_en_i ? FW'(1) : FW'(0));
        rd_ptr_d = rd_ptr_q + (rd_en_i ? FW'(1) : FW'(0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign fill_o    = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (fill_o == '0);
    assign full_o    = (fill_o == FW'(DEPTH));

endmodule

// File: rtl/multi_queue_fifo_service.sv
// N-queue FIFO: ingress steered by channel id, round-robin egress into one output register,
// with per-queue fill/almost-full, optional drop-on-full with overflow counts, and beat stats.
module multi_queue_fifo_service
    import mq_fifo_pkg::*;
#(
    parameter int unsigned NUM_QUEUES       = 4,
    parameter int unsigned SYMBOLS_PER_BEAT = 64,
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned FIFO_DEPTH       = 512,
    parameter int unsigned FULL_LEVEL       = 450,
    parameter bit          DROP_ON_FULL     = 1'b0,
    localparam int unsigned CW = calc_cw(NUM_QUEUES),
    localparam int unsigned FW = calc_fw(FIFO_DEPTH),
    localparam int unsigned DW = calc_dw(SYMBOLS_PER_BEAT, BITS_PER_SYMBOL)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DW-1:0]            in_data_i,
    input  logic [CW-1:0]            in_chan_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [DW-1:0]            out_data_o,
    output logic [CW-1:0]            out_chan_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_QUEUES*FW-1:0] fill_level_o,
    output logic [NUM_QUEUES-1:0]    almost_full_o,
    output logic [NUM_QUEUES*32-1:0] overflow_o,
    output logic [31:0]              stats_in_o,
    output logic [31:0]              stats_out_o
);

    logic [NUM_QUEUES-1:0] push, pop, q_empty, q_full;
    logic [DW-1:0]         q_data [NUM_QUEUES];
    logic [FW-1:0]         q_fill [NUM_QUEUES];

    logic          accept, in_full, load, grant_vld;
    logic [CW-1:0] grant_idx, idx;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] out_chan_q, out_chan_d;
    logic [CW-1:0] rr_q, rr_d;
    logic [31:0]   stats_in_q, stats_in_d, stats_out_q, stats_out_d;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        mq_queue #(
            .DW    (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_queue (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_en_i   (push[q]),
            .wr_data_i (in_data_i),
            .rd_en_i   (pop[q]),
            .rd_data_o (q_data[q]),
            .empty_o   (q_empty[q]),
            .full_o    (q_full[q]),
            .fill_o    (q_fill[q])
        );
        assign fill_level_o[q*FW +: FW] = q_fill[q];
        assign almost_full_o[q]         = (q_fill[q] >= FW'(FULL_LEVEL));
    end

    // Full is registered state, so a same-cycle pop never frees space for this cycle's push.
    assign in_full    = q_full[in_chan_i];
    assign in_ready_o = !rst_i && (DROP_ON_FULL || !in_full);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        push            = '0;
        push[in_chan_i] = accept && !in_full;
    end

    // Scan from the highest offset down so the nearest non-empty queue at/after rr_q wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        idx       = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            idx = rr_q + CW'(i);
            if (!q_empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign load = !out_valid_q || out_ready_i;

    always_comb begin
        pop = '0;
        if (load && grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_d        = rr_q;
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = q_data[grant_idx];
                out_chan_d = grant_idx;
                rr_d       = grant_idx + CW'(1);
            end
        end
        stats_in_d  = stats_in_q + {31'd0, accept};
        stats_out_d = stats_out_q + {31'd0, out_valid_q && out_ready_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_q        <= '0;
            stats_in_q  <= '0;
            stats_out_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_q        <= rr_d;
            stats_in_q  <= stats_in_d;
            stats_out_q <= stats_out_d;
        end
    end

    if (DROP_ON_FULL) begin : g_drop
        logic drop;
        assign drop = accept && in_full;
        for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_ovf
            logic [31:0] cnt_q, cnt_d;
            assign cnt_d = cnt_q + {31'd0, drop && (in_chan_i == CW'(q))};
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
            assign overflow_o[q*32 +: 32] = cnt_q;
        end
    end else begin : g_no_drop
        assign overflow_o = '0;
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;
    assign stats_in_o  = stats_in_q;
    assign stats_out_o = stats_out_q;

endmodule

// File: tb/tb_multi_queue_fifo_service.sv
// Bench for multi_queue_fifo_service: a backpressure instance and a drop-on-full instance share stimulus.
module tb_multi_queue_fifo_service;

    localparam int unsigned NQ = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned FW = 10;
    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_chan;
    logic          in_valid, out_ready;

    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [DW-1:0] out_data0, out_data1;
    logic [CW-1:0] out_chan0, out_chan1;
    logic [NQ*FW-1:0] fill0, fill1;
    logic [NQ-1:0]    af0, af1;
    logic [NQ*32-1:0] ovf0, ovf1;
    logic [31:0]      sin0, sout0, sin1, sout1;

    always #5 clk = ~clk;

    multi_queue_fifo_service #(.DROP_ON_FULL(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_chan_i(in_chan),
        .in_valid_i(in_valid), .in_ready_o(in_ready0), .out_data_o(out_data0),
        .out_chan_o(out_chan0), .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .fill_level_o(fill0), .almost_full_o(af0), .overflow_o(ovf0),
        .stats_in_o(sin0), .stats_out_o(sout0)
    );

    multi_queue_fifo_service #(.DROP_ON_FULL(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_chan_i(in_chan),
        .in_valid_i(in_valid), .in_ready_o(in_ready1), .out_data_o(out_data1),
        .out_chan_o(out_chan1), .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .fill_level_o(fill1), .almost_full_o(af1), .overflow_o(ovf1),
        .stats_in_o(sin1), .stats_out_o(sout1)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [CW-1:0] chan;
        logic [63:0]   data;
    } obs_t;

    obs_t got0[$];
    obs_t got1[$];

    logic          stall0 = 1'b0;
    logic [63:0]   stall_data;
    logic [CW-1:0] stall_chan;

    // Egress monitor: logs handshakes and checks the output register holds while stalled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                chk("stall_valid", {63'd0, out_valid0}, 64'd1);
                chk("stall_data", out_data0[63:0], stall_data);
                chk("stall_chan", {62'd0, out_chan0}, {62'd0, stall_chan});
            end
            if (out_valid0 && out_ready) got0.push_back('{chan: out_chan0, data: out_data0[63:0]});
            if (out_valid1 && out_ready) got1.push_back('{chan: out_chan1, data: out_data1[63:0]});
            stall0     = out_valid0 && !out_ready;
            stall_data = out_data0[63:0];
            stall_chan = out_chan0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got0.delete();
        got1.delete();
        tick();
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [63:0] d);
        in_chan  = c;
        in_data  = DW'(d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int bound);
        out_ready = 1'b1;
        for (int i = 0; i < bound && (got0.size() < n || got1.size() < n); i++) tick();
        chk("drain_count0", 64'(got0.size()), 64'(n));
        chk("drain_count1", 64'(got1.size()), 64'(n));
        tick();
    endtask

    typedef struct {
        int            grp;
        logic [CW-1:0] chan;
        logic [63:0]   data;
        logic [CW-1:0] exp_chan;
        logic [63:0]   exp_data;
    } vec_t;

    vec_t tbl[$];
    logic [63:0] mq[NQ][$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_chan = '0; in_data = '0;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, base, accepted, cyc;
        logic [63:0] rd;

        // Push order vs required egress order; all pushes land while egress is stalled.
        tbl.push_back('{0, 2'd2, 64'hA1, 2'd2, 64'hA1});
        tbl.push_back('{0, 2'd2, 64'hA2, 2'd2, 64'hA2});
        tbl.push_back('{0, 2'd2, 64'hA3, 2'd2, 64'hA3});
        tbl.push_back('{1, 2'd0, 64'hB0, 2'd0, 64'hB0});
        tbl.push_back('{1, 2'd1, 64'hB1, 2'd1, 64'hB1});
        tbl.push_back('{1, 2'd2, 64'hB2, 2'd2, 64'hB2});
        tbl.push_back('{1, 2'd3, 64'hB3, 2'd3, 64'hB3});
        tbl.push_back('{1, 2'd3, 64'hC3, 2'd0, 64'hC0});
        tbl.push_back('{1, 2'd0, 64'hC0, 2'd3, 64'hC3});

        tick();
        chk("rst_in_ready", {63'd0, in_ready0}, 64'd0);
        do_reset();
        chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
        chk("rst_out_data", out_data0[63:0], 64'd0);
        chk("rst_fill", 64'(fill0), 64'd0);
        chk("rst_af", {60'd0, af0}, 64'd0);
        chk("rst_stats", {sin0, sout0}, 64'd0);
        chk("rst_ovf1", ovf1[63:0], 64'd0);

        // Latency: accepted in cycle t, visible in t+2.
        out_ready = 1'b1;
        push(2'd2, 64'hA1);
        chk("lat_t1_valid", {63'd0, out_valid0}, 64'd0);
        tick();
        chk("lat_t2_valid", {63'd0, out_valid0}, 64'd1);
        chk("lat_t2_data", out_data0[63:0], 64'hA1);
        chk("lat_t2_chan", {62'd0, out_chan0}, 64'd2);
        push(2'd2, 64'hA2);
        push(2'd2, 64'hA3);
        drain(3, 20);
        chk("lat_order", {got0[1].data[7:0], got0[2].data[7:0]}, 64'hA2A3);
        chk("lat_stats", {sin0, sout0}, {32'd3, 32'd3});

        for (int g = 0; g < 2; g++) begin
            do_reset();
            n = 0;
            foreach (tbl[i]) if (tbl[i].grp == g) begin
                push(tbl[i].chan, tbl[i].data);
                n++;
            end
            drain(n, 50);
            base = 0;
            foreach (tbl[i]) if (tbl[i].grp == g) begin
                if (base < got0.size()) begin
                    chk($sformatf("tbl%0d_chan%0d", g, base), {62'd0, got0[base].chan},
                        {62'd0, tbl[i].exp_chan});
                    chk($sformatf("tbl%0d_data%0d", g, base), got0[base].data, tbl[i].exp_data);
                end
                base++;
            end
            chk($sformatf("tbl%0d_stats", g), {sin0, sout0}, {32'(n), 32'(n)});
        end

        // Fill to the full boundary with egress stalled; the drop instance then drops 5.
        do_reset();
        for (int k = 1; k <= 450; k++) push(2'd1, 64'(k));
        chk("af_below_fill", 64'(fill0[FW +: FW]), 64'd449);
        chk("af_below", {63'd0, af0[1]}, 64'd0);
        push(2'd1, 64'd451);
        chk("af_at_fill", 64'(fill0[FW +: FW]), 64'd450);
        chk("af_at", {60'd0, af0}, 64'b0010);
        for (int k = 452; k <= 513; k++) push(2'd1, 64'(k));
        #1;
        chk("full_fill", 64'(fill0[FW +: FW]), 64'd512);
        chk("full_in_ready", {63'd0, in_ready0}, 64'd0);
        chk("drop_in_ready", {63'd0, in_ready1}, 64'd1);
        in_chan = 2'd0;
        #1;
        chk("other_in_ready", {63'd0, in_ready0}, 64'd1);
        tick();
        in_chan  = 2'd1;
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("ovf1_q1", 64'(ovf1[32 +: 32]), 64'd5);
        chk("ovf1_others", {ovf1[127:64], ovf1[31:0]}, 64'd0);
        chk("ovf0_all", ovf0[63:0] | ovf0[127:64], 64'd0);
        chk("stats_in_both", {sin0, sin1}, {32'd513, 32'd518});
        chk("drop_fill", 64'(fill1[FW +: FW]), 64'd512);
        drain(513, 1200);
        bad = 0;
        for (int i = 0; i < 513; i++) begin
            if (i >= got0.size() || got0[i].data != 64'(i + 1) || got0[i].chan != 2'd1) bad++;
            if (i >= got1.size() || got1[i].data != 64'(i + 1) || got1[i].chan != 2'd1) bad++;
        end
        chk("full_drain_order", 64'(bad), 64'd0);
        chk("full_drain_fill", 64'(fill0), 64'd0);
        chk("full_drain_af", {60'd0, af0}, 64'd0);
        chk("full_drain_stats", {sin0, sout0}, {32'd513, 32'd513});

        // Random traffic with random egress stalls against per-queue reference lists.
        do_reset();
        for (int q = 0; q < NQ; q++) mq[q].delete();
        accepted = 0;
        cyc      = 0;
        while (accepted < 2000 && cyc < 40000) begin
            in_chan   = CW'($urandom_range(0, NQ - 1));
            rd        = {$urandom, $urandom};
            in_data   = DW'(rd);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            #1;
            if (in_valid && in_ready0) begin
                mq[in_chan].push_back(rd);
                accepted++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_accepted", 64'(accepted), 64'd2000);
        out_ready = 1'b1;
        for (int i = 0; i < 5000 && got0.size() < accepted; i++) tick();
        tick();
        chk("rand_drained", 64'(got0.size()), 64'(accepted));
        bad = 0;
        foreach (got0[i]) begin
            if (mq[got0[i].chan].size() == 0 || mq[got0[i].chan][0] != got0[i].data) bad++;
            else void'(mq[got0[i].chan].pop_front());
        end
        for (int q = 0; q < NQ; q++) bad += mq[q].size();
        chk("rand_order", 64'(bad), 64'd0);
        chk("rand_stats", {sin0, sout0}, {32'(accepted), 32'(accepted)});
        chk("rand_idle", {63'd0, out_valid0}, 64'd0);

        // Reset in the middle of a stalled burst.
        do_reset();
        for (int i = 0; i < 11; i++) push(CW'($urandom_range(0, NQ - 1)), 64'(100 + i));
        chk("mid_valid", {63'd0, out_valid0}, 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {63'd0, out_valid0}, 64'd0);
        chk("mid_rst_fill", 64'(fill0), 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready0}, 64'd0);
        chk("mid_rst_stats", {sin0, sout0}, 64'd0);
        rst = 1'b0;
        got0.delete();
        got1.delete();
        tick();
        out_ready = 1'b1;
        push(2'd3, 64'h77);
        chk("post_rst_t1", {63'd0, out_valid0}, 64'd0);
        tick();
        chk("post_rst_t2", {63'd0, out_valid0}, 64'd1);
        chk("post_rst_data", out_data0[63:0], 64'h77);
        chk("post_rst_chan", {62'd0, out_chan0}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
